datapath: RTL and testbench
===========================

# datapath

Execution datapath of the single-accumulator processor. Holds the instruction register (IR), accumulator (ACC) and program counter (PC), and contains the 8-bit ALU and the operand/address multiplexers. It is steered cycle by cycle by the control decoder's outputs. It returns `ir` plus the raw ALU `carry`/`zero` to the decoder, which registers the flags itself. It drives the single-port memory/IO bus.

## Interface
Parameters:
- None. All widths are fixed: 8-bit data, 8-bit address, 4-bit opcode, 4-bit operand.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  reset. One clock; reset is asynchronous and active-low.
- `rw`  in  1  1 = write memory this cycle.
- `alu`  in  5  ALU control, bit-mapped (see Operation).
- `muxa`  in  1  A-operand select: 0 = ACC, 1 = PC.
- `muxb`  in  1  1 = data-page access; B = `mem_din`.
- `muxc`  in  1  1 = IO-page access; B = `mem_din`.
- `en_ir`  in  1  load IR from `mem_din`.
- `en_da`  in  1  load ACC from ALU result.
- `en_pc`  in  1  load PC from ALU result.
- `mem_din`  in  8  read data from memory/IO.
- `mem_addr`  out  8  bus address.
- `mem_dout`  out  8  write data; always equals the ALU result.
- `mem_we`  out  1  write strobe; equals `rw`.
- `ir`  out  8  IR contents; `[7:4]` is the opcode, `[3:0]` is the operand.
- `carry`  out  1  ALU carry-out (combinational).
- `zero`  out  1  1 when the ALU result is 0x00 (combinational).
- `acc`  out  8  ACC contents (debug/observation).

## Operation
- **Raw B operand.** `(muxb|muxc) ? mem_din : {PC[7:4], ir[3:0]}`. The second form is the page-relative jump target.
- **Effective B.**
  - `alu[4]=1`: B forced to 0x00.
  - Then `alu[3]=1`: B bitwise inverted.
- **Carry-in.** `cin = alu[2]`.
- **Function select, `alu[1:0]`.**
  - 00: `{cout,res} = A + B + cin`, computed 9 bits wide.
  - 01: `res = A & B`.
  - 10: `res = A`.
  - 11: `res = B`.
  - `carry = cout` for 00; 0 for all other functions. `zero = (res == 8'h00)` for every function.
- **Codes the decoder issues.**
  - `00000` add.
  - `01100` sub: A + ~B + 1. `carry=1` means no borrow.
  - `00001` and.
  - `00011` load, input and jumps.
  - `00010` output: ACC passes to `mem_dout`.
  - `10100` with `muxa=1`: PC + 1.
- **Address.**
  - `muxc=1`: `{4'hF, ir[3:0]}` (IO page 0xF0–0xFF). `muxc` has priority over `muxb`.
  - Else `muxb=1`: `{4'hE, ir[3:0]}` (data page 0xE0–0xEF).
  - Else: PC.
- **Registers.**
  - IR <= `mem_din` when `en_ir`.
  - ACC <= `res` when `en_da`.
  - PC <= `res` when `en_pc`.
  - The three enables are independent. When several are asserted in the same cycle, each register loads its own source on the same edge.
- **No internal FSM.** Sequencing belongs to the decoder. All 32 `alu` codes produce a defined result; there is no illegal code.

## Timing
- **Reset.** `clr` low immediately forces IR = ACC = PC = 0x00, without waiting for a clock. The outputs follow combinationally:
  - `ir` = 0x00, `acc` = 0x00.
  - `mem_addr` = 0x00 when `muxb=muxc=0`.
  - `mem_we` = `rw`.
- **Reset mid-operation.** An in-flight register load is lost. The first edge after `clr` rises loads normally.
- **Combinational outputs.** `mem_addr`, `mem_dout`, `mem_we`, `carry` and `zero` respond in the same cycle to control and register changes. Memory read is combinational: `mem_din` is valid within the same cycle.
- **Register latency.** A register's new value is visible one cycle after its enable, i.e. at the next rising edge.
- **Wrap-around.** PC 0xFF + 1 gives 0x00 with `carry=1`. This is not an error; the decoder ignores flags outside add/sub/and.
- **Same-cycle use.** An `en_ir` and `muxb` in the same cycle address the data page using the old `ir[3:0]`. The decoder never issues this combination.

## Test plan
- **Reset.** Assert `clr=0` mid-cycle with ACC = 0x5A → `acc`, `ir` and `mem_addr` read 0x00 before the next edge. After release, with all enables low, values hold.
- **Fetch.** PC = 0x03, `mem_din` = 0x47, `en_ir=1` → `mem_addr` = 0x03; next cycle `ir` = 0x47.
- **Add.**
  - ACC = 0xF0, `ir` = 0x45, `mem_din` = 0x20, `muxb=1`, `alu=00000`, `en_da=1` → `mem_addr` = 0xE5, `carry=1`, `zero=0`; ACC becomes 0x10.
  - Repeat with ACC = 0xE0 → `zero=1`, ACC = 0x00.
- **Sub.** ACC = 0x05, `mem_din` = 0x07, `alu=01100` → `res` = 0xFE, `carry=0`. With ACC = 0x07 → `res` = 0x00, `carry=1`, `zero=1`.
- **Increment and jump.**
  - PC = 0xFF, `muxa=1`, `alu=10100`, `en_pc=1` → PC = 0x00, `carry=1`.
  - PC = 0x34, `ir` = 0x8B, `alu=00011`, `en_pc=1` → PC = 0x3B.
- **Output.** ACC = 0x99, `ir` = 0xE2, `muxc=1`, `alu=00010`, `rw=1` → `mem_addr` = 0xF2, `mem_dout` = 0x99, `mem_we=1`; ACC unchanged.

Source files
------------

// File: rtl/datapath_if.sv
// Control/memory bus between the control decoder (master) and the execution datapath (slave).
interface datapath_if;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 8;
  localparam int unsigned ALW = 5;

  // Decoder controls and memory read data
  logic           rw;
  logic [ALW-1:0] alu;
  logic           muxa;
  logic           muxb;
  logic           muxc;
  logic           en_ir;
  logic           en_da;
  logic           en_pc;
  logic [DW-1:0]  mem_din;

  // Datapath returns: bus drive, IR, raw flags, ACC
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_dout;
  logic           mem_we;
  logic [DW-1:0]  ir;
  logic           carry;
  logic           zero;
  logic [DW-1:0]  acc;

  modport master (
    output rw, alu, muxa, muxb, muxc, en_ir, en_da, en_pc, mem_din,
    input  mem_addr, mem_dout, mem_we, ir, carry, zero, acc
  );

  modport slave (
    input  rw, alu, muxa, muxb, muxc, en_ir, en_da, en_pc, mem_din,
    output mem_addr, mem_dout, mem_we, ir, carry, zero, acc
  );
endinterface

// File: rtl/datapath.sv
// Single-accumulator execution datapath: IR/ACC/PC, 8-bit ALU, operand and address muxes.
// Steered cycle by cycle by the decoder; flags are returned raw for the decoder to register.
module datapath (
  input  logic       clk,
  input  logic       clr,
  datapath_if.slave  bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned OW = 4;

  typedef enum logic [1:0] {
    FN_ADD  = 2'b00,
    FN_AND  = 2'b01,
    FN_PASA = 2'b10,
    FN_PASB = 2'b11
  } alu_fn_e;

  localparam logic [OW-1:0] DATA_PAGE = 4'hE;
  localparam logic [OW-1:0] IO_PAGE   = 4'hF;

  logic [DW-1:0] ir_q;
  logic [DW-1:0] acc_q;
  logic [AW-1:0] pc_q;

  logic [DW-1:0] a_opnd;
  logic [DW-1:0] b_raw;
  logic [DW-1:0] b_eff;
  logic          cin;
  logic [DW:0]   sum;
  alu_fn_e       fn;
  logic [DW-1:0] res;
  logic          cout;
  logic [AW-1:0] addr;

  // Operand selection; the non-memory B form is the page-relative jump target
  always_comb begin
    a_opnd = bus.muxa ? pc_q : acc_q;
    b_raw  = (bus.muxb | bus.muxc) ? bus.mem_din : {pc_q[AW-1:OW], ir_q[OW-1:0]};
    b_eff  = b_raw;
    if (bus.alu[4]) b_eff = '0;
    if (bus.alu[3]) b_eff = ~b_eff;
    cin    = bus.alu[2];
  end

  // ALU: every one of the 32 codes yields a defined result
  always_comb begin
    res  = '0;
    cout = 1'b0;
    fn   = alu_fn_e'(bus.alu[1:0]);
    sum  = (DW+1)'(a_opnd) + (DW+1)'(b_eff) + (DW+1)'(cin);
    unique case (fn)
      FN_ADD: begin
        res  = sum[DW-1:0];
        cout = sum[DW];
      end
      FN_AND:  res = a_opnd & b_eff;
      FN_PASA: res = a_opnd;
      FN_PASB: res = b_eff;
      default: res = '0;
    endcase
  end

  // Bus address: IO page wins over data page, otherwise instruction fetch from PC
  always_comb begin
    addr = pc_q;
    if (bus.muxc)      addr = {IO_PAGE, ir_q[OW-1:0]};
    else if (bus.muxb) addr = {DATA_PAGE, ir_q[OW-1:0]};
  end

  // Independent register loads; reset discards any load in flight
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ir_q  <= '0;
      acc_q <= '0;
      pc_q  <= '0;
    end else begin
      if (bus.en_ir) ir_q  <= bus.mem_din;
      if (bus.en_da) acc_q <= res;
      if (bus.en_pc) pc_q  <= res;
    end
  end

  assign bus.mem_addr = addr;
  assign bus.mem_dout = res;
  assign bus.mem_we   = bus.rw;
  assign bus.ir       = ir_q;
  assign bus.carry    = cout;
  assign bus.zero     = (res == '0);
  assign bus.acc      = acc_q;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath with hand-computed expected values.
module tb_datapath;
  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  datapath_if bus ();

  datapath dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.rw = 0; bus.alu = 5'b00000; bus.muxa = 0; bus.muxb = 0; bus.muxc = 0;
    bus.en_ir = 0; bus.en_da = 0; bus.en_pc = 0; bus.mem_din = 8'h00;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic [7:0] v);
    idle(); bus.muxb = 1; bus.alu = 5'b00011; bus.mem_din = v; bus.en_da = 1;
    step(); idle();
  endtask

  task automatic set_pc(input logic [7:0] v);
    idle(); bus.muxb = 1; bus.alu = 5'b00011; bus.mem_din = v; bus.en_pc = 1;
    step(); idle();
  endtask

  task automatic set_ir(input logic [7:0] v);
    idle(); bus.mem_din = v; bus.en_ir = 1;
    step(); idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    clr = 0;
    #3;
    check("rst_acc", bus.acc, 8'h00);
    check("rst_ir", bus.ir, 8'h00);
    check("rst_addr", bus.mem_addr, 8'h00);
    @(negedge clk);
    clr = 1;
    step();

    // Reset asserted mid-cycle clears registers before the next edge
    set_ir(8'h3C);
    set_acc(8'h5A);
    check("pre_rst_acc", bus.acc, 8'h5A);
    check("pre_rst_ir", bus.ir, 8'h3C);
    #2;
    clr = 0;
    bus.rw = 1;
    #1;
    check("mid_rst_acc", bus.acc, 8'h00);
    check("mid_rst_ir", bus.ir, 8'h00);
    check("mid_rst_addr", bus.mem_addr, 8'h00);
    check("mid_rst_we", 8'(bus.mem_we), 8'h01);
    // A load attempted while reset is held is lost
    bus.rw = 0; bus.muxb = 1; bus.alu = 5'b00011; bus.mem_din = 8'h77; bus.en_da = 1;
    step();
    check("rst_load_lost", bus.acc, 8'h00);
    idle();
    #2;
    clr = 1;
    step();
    check("hold_acc", bus.acc, 8'h00);
    check("hold_ir", bus.ir, 8'h00);

    // Fetch
    set_pc(8'h03);
    bus.mem_din = 8'h47; bus.en_ir = 1;
    #1;
    check("fetch_addr", bus.mem_addr, 8'h03);
    step(); idle();
    check("fetch_ir", bus.ir, 8'h47);

    // Add with carry out, then add to zero
    set_ir(8'h45);
    set_acc(8'hF0);
    bus.muxb = 1; bus.mem_din = 8'h20; bus.alu = 5'b00000; bus.en_da = 1;
    #1;
    check("add_addr", bus.mem_addr, 8'hE5);
    check("add_carry", 8'(bus.carry), 8'h01);
    check("add_zero", 8'(bus.zero), 8'h00);
    step(); idle();
    check("add_acc", bus.acc, 8'h10);
    set_acc(8'hE0);
    bus.muxb = 1; bus.mem_din = 8'h20; bus.alu = 5'b00000; bus.en_da = 1;
    #1;
    check("add0_zero", 8'(bus.zero), 8'h01);
    check("add0_carry", 8'(bus.carry), 8'h01);
    step(); idle();
    check("add0_acc", bus.acc, 8'h00);

    // Subtract with borrow, then exact subtract
    set_acc(8'h05);
    bus.muxb = 1; bus.mem_din = 8'h07; bus.alu = 5'b01100;
    #1;
    check("sub_res", bus.mem_dout, 8'hFE);
    check("sub_carry", 8'(bus.carry), 8'h00);
    check("sub_zero", 8'(bus.zero), 8'h00);
    set_acc(8'h07);
    bus.muxb = 1; bus.mem_din = 8'h07; bus.alu = 5'b01100;
    #1;
    check("sub0_res", bus.mem_dout, 8'h00);
    check("sub0_carry", 8'(bus.carry), 8'h01);
    check("sub0_zero", 8'(bus.zero), 8'h01);
    idle();

    // AND; carry is forced low for non-add functions
    set_acc(8'h3C);
    bus.muxb = 1; bus.mem_din = 8'hFF; bus.alu = 5'b00001;
    #1;
    check("and_res_ff", bus.mem_dout, 8'h3C);
    bus.mem_din = 8'h0F;
    #1;
    check("and_res", bus.mem_dout, 8'h0C);
    check("and_carry", 8'(bus.carry), 8'h00);
    idle();

    // PC increment wraps
    set_pc(8'hFF);
    bus.muxa = 1; bus.alu = 5'b10100; bus.en_pc = 1;
    #1;
    check("inc_res", bus.mem_dout, 8'h00);
    check("inc_carry", 8'(bus.carry), 8'h01);
    step(); idle();
    #1;
    check("inc_pc", bus.mem_addr, 8'h00);

    // Page-relative jump
    set_ir(8'h8B);
    set_pc(8'h34);
    bus.alu = 5'b00011; bus.en_pc = 1;
    #1;
    check("jmp_target", bus.mem_dout, 8'h3B);
    step(); idle();
    #1;
    check("jmp_pc", bus.mem_addr, 8'h3B);

    // Output to IO page; muxc takes priority over muxb
    set_ir(8'hE2);
    set_acc(8'h99);
    bus.muxc = 1; bus.alu = 5'b00010; bus.rw = 1; bus.mem_din = 8'h11;
    #1;
    check("out_addr", bus.mem_addr, 8'hF2);
    check("out_dout", bus.mem_dout, 8'h99);
    check("out_we", 8'(bus.mem_we), 8'h01);
    bus.muxb = 1;
    #1;
    check("prio_addr", bus.mem_addr, 8'hF2);
    step(); idle();
    check("out_acc", bus.acc, 8'h99);

    // Simultaneous enables each load on the same edge
    bus.muxb = 1; bus.alu = 5'b00011; bus.mem_din = 8'h6D;
    bus.en_ir = 1; bus.en_da = 1; bus.en_pc = 1;
    step(); idle();
    #1;
    check("multi_ir", bus.ir, 8'h6D);
    check("multi_acc", bus.acc, 8'h6D);
    check("multi_pc", bus.mem_addr, 8'h6D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1);
  end
endmodule
